// File: rtl/game_credit_pkg.sv
// Shared types and arithmetic helpers for the multi-channel game credit controller.
package game_credit_pkg;

  // Helper datapath width; channels keep the low W bits.
  localparam int CW = 32;

  typedef enum logic [1:0] {EMPTY, RUN, LOW, PAUSE} state_t;

  function automatic logic [CW-1:0] cost_of(input logic [1:0] boost);
    return CW'(1) << boost;
  endfunction

  // Returns {ovf, sum}; sum clamps to 2^w-1.
  function automatic logic [CW:0] sat_add(input logic [CW-1:0] a,
                                          input logic [CW-1:0] b,
                                          input int w);
    logic [CW:0] sum;
    logic [CW:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = ((CW+1)'(1) << w) - (CW+1)'(1);
    if (sum > max) return {1'b1, max[CW-1:0]};
    return {1'b0, sum[CW-1:0]};
  endfunction

endpackage

// File: rtl/game_credit_chan.sv
// One credit channel: saturating top-up, rate-selectable drain, status FSM and pulses.
module game_credit_chan
  import game_credit_pkg::*;
#(
  parameter int W      = 10,
  parameter int LOW_TH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] money,
  input  logic         set,
  input  logic [1:0]   boost,
  input  logic         pause,
  output logic [W-1:0] remain,
  output logic         yellow,
  output logic         red,
  output logic         paused,
  output logic         expire,
  output logic         ovf
);

  state_t       state, state_nxt;
  logic [W-1:0] rem_nxt;
  logic         exp_nxt, ovf_nxt;
  logic [CW-1:0] cost_w;
  logic [CW:0]   sum_w;
  logic [W-1:0]  cost;

  assign cost_w = cost_of(boost);
  assign cost   = cost_w[W-1:0];
  assign sum_w  = sat_add(CW'(remain), CW'(money), W);

  // Upper helper bits are zero by construction for W-bit operands.
  logic unused_hi;
  assign unused_hi = ^{cost_w[CW-1:W], sum_w[CW-1:W]};

  always_comb begin
    rem_nxt = remain;
    exp_nxt = 1'b0;
    ovf_nxt = 1'b0;
    if (set) begin
      rem_nxt = sum_w[W-1:0];
      ovf_nxt = sum_w[CW];
    end else if (!pause && remain != '0) begin
      rem_nxt = (remain >= cost) ? remain - cost : '0;
      exp_nxt = (rem_nxt == '0);
    end

    // Empty wins over pause so a drained channel never reads as paused.
    if (rem_nxt == '0)              state_nxt = EMPTY;
    else if (pause)                 state_nxt = PAUSE;
    else if (rem_nxt < W'(LOW_TH))  state_nxt = LOW;
    else                            state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      remain <= '0;
      expire <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      remain <= rem_nxt;
      expire <= exp_nxt;
      ovf    <= ovf_nxt;
    end
  end

  assign red    = (state == EMPTY);
  assign yellow = (state == LOW);
  assign paused = (state == PAUSE);

endmodule

// File: rtl/game_credit_ctrl.sv
// N_CH independent credit channels sharing packed input/output buses.
module game_credit_ctrl
  import game_credit_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int W      = 10,
  parameter int LOW_TH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] money,
  input  logic [N_CH-1:0]   set,
  input  logic [N_CH*2-1:0] boost,
  input  logic [N_CH-1:0]   pause,
  output logic [N_CH*W-1:0] remain,
  output logic [N_CH-1:0]   yellow,
  output logic [N_CH-1:0]   red,
  output logic [N_CH-1:0]   paused,
  output logic [N_CH-1:0]   expire,
  output logic [N_CH-1:0]   ovf
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    game_credit_chan #(.W(W), .LOW_TH(LOW_TH)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .money  (money[i*W +: W]),
      .set    (set[i]),
      .boost  (boost[i*2 +: 2]),
      .pause  (pause[i]),
      .remain (remain[i*W +: W]),
      .yellow (yellow[i]),
      .red    (red[i]),
      .paused (paused[i]),
      .expire (expire[i]),
      .ovf    (ovf[i])
    );
  end

endmodule
